// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch requester and a data requester.
// Data has priority; fetch is forced through after STARVE_LIMIT data grants in a row.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic [1:0]  dbg_state_o,
    output logic [3:0]  dbg_starve_cnt_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic        read_q;
    logic        write_q;
    logic        imem_resp_q;
    logic        dmem_resp_q;
    logic        dmem_req;
    logic        imem_wins;

    // Handshake: a requester raises read/write and holds it (with stable fields) until its
    // one-cycle resp pulse; the shared port strobe is likewise held until mem_resp.
    always_comb begin
        dmem_req     = dmem_read | dmem_write;
        imem_wins    = imem_read & (~dmem_req | (starve_cnt_q == LIMIT));
        starve_cnt_d = starve_cnt_q;
        if (imem_read && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            be_q         <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imem_wins) begin
                        state_q      <= I_BUSY;
                        starve_cnt_q <= '0;
                        addr_q       <= imem_address;
                        be_q         <= 4'hF;
                        read_q       <= 1'b1;
                        write_q      <= 1'b0;
                    end else if (dmem_req) begin
                        // A simultaneous read and write is served as the write alone.
                        state_q      <= D_BUSY;
                        starve_cnt_q <= starve_cnt_d;
                        addr_q       <= dmem_address;
                        wdata_q      <= dmem_wdata;
                        be_q         <= dmem_write ? dmem_byte_enable : 4'hF;
                        read_q       <= ~dmem_write;
                        write_q      <= dmem_write;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state_q     <= RESP;
                        rdata_q     <= mem_rdata;
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        imem_resp_q <= (state_q == I_BUSY);
                        dmem_resp_q <= (state_q == D_BUSY);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    imem_resp_q <= 1'b0;
                    dmem_resp_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read         = read_q;
    assign mem_write        = write_q;
    assign mem_address      = addr_q;
    assign mem_wdata        = wdata_q;
    assign mem_byte_enable  = be_q;
    assign imem_resp        = imem_resp_q;
    assign dmem_resp        = dmem_resp_q;
    assign imem_rdata       = rdata_q;
    assign dmem_rdata       = rdata_q;
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = starve_cnt_q;
endmodule
